uart_tx_arb: RTL and testbench

Two-requester scheduler for the shared UART transmitter. Buffers bytes from two independent sources (requester 0: keyboard ASCII stream; requester 1: debug/CPU console) in per-requester FIFOs. Grants the transmitter round-robin, and sequences one `tx_start` pulse per byte, holding off until the transmitter reports `tx_done_tick`. It sits between the byte producers and `uart_tx`; the baud tick generator is untouched.

---
 rtl/uart_arb_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/uart_tx_arb.sv | 136 +++++++++++++
 tb/tb_uart_tx_arb.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART transmit scheduler.
package uart_arb_pkg;

  // Scheduler FSM: IDLE picks and pops, START fires the transmitter,
  // WAIT holds until the transmitter reports completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Requester indices into the per-FIFO vectors.
  localparam int REQ_KBD = 0;
  localparam int REQ_DBG = 1;
  localparam int NUM_REQ = 2;

  // Round-robin winner selection. With a single non-empty FIFO that FIFO
  // wins. With both non-empty, the requester not served last time wins.
  // Only meaningful when at least one bit of nonempty is set.
  function automatic logic rr_pick(input logic [1:0] nonempty, input logic last);
    logic win;
    if (nonempty[0] && nonempty[1]) begin
      win = ~last;
    end else if (nonempty[0]) begin
      win = 1'b0;
    end else begin
      win = 1'b1;
    end
    return win;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy counter. A push on a full FIFO is
// dropped even when the same cycle pops; the head is visible combinationally
// so the consumer can capture it on the popping edge.
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          do_push;
  logic          do_pop;

  // Full is decided from the registered count only, so a simultaneous pop
  // never makes room for the push in the same cycle.
  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr_reg];

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Occupancy changes by at most one per cycle.
  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Two-requester round-robin scheduler in front of the shared UART
// transmitter. Each requester has its own FIFO; one byte at a time is popped,
// announced with a single tx_start pulse, and held until tx_done_tick.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          tx_start,
  output logic [DW-1:0] tx_data,
  input  logic          tx_done_tick,
  output logic          tx_src,
  output logic          busy,
  output logic [1:0]    ovf,
  input  logic          ovf_clr
);

  logic [NUM_REQ-1:0] push_vec;
  logic [NUM_REQ-1:0] pop_vec;
  logic [NUM_REQ-1:0] full_vec;
  logic [NUM_REQ-1:0] empty_vec;
  logic [DW-1:0]      push_data_arr [NUM_REQ];
  logic [DW-1:0]      pop_data_arr  [NUM_REQ];

  arb_state_t    state_reg;
  arb_state_t    state_next;
  logic [DW-1:0] tx_data_reg;
  logic [DW-1:0] tx_data_next;
  logic          tx_src_reg;
  logic          tx_src_next;
  logic          last_reg;
  logic          last_next;
  logic [1:0]    ovf_reg;
  logic [1:0]    ovf_next;
  logic          winner;

  assign push_vec[REQ_KBD]      = req0_valid;
  assign push_vec[REQ_DBG]      = req1_valid;
  assign push_data_arr[REQ_KBD] = req0_data;
  assign push_data_arr[REQ_DBG] = req1_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
      sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_vec[gi]),
        .push_data (push_data_arr[gi]),
        .pop       (pop_vec[gi]),
        .pop_data  (pop_data_arr[gi]),
        .full      (full_vec[gi]),
        .empty     (empty_vec[gi])
      );
    end
  endgenerate

  assign winner = rr_pick(~empty_vec, last_reg);

  // Next-state logic: pop the round-robin winner from IDLE, pulse in START,
  // and wait for the transmitter to finish before scheduling again.
  always_comb begin
    state_next   = state_reg;
    tx_data_next = tx_data_reg;
    tx_src_next  = tx_src_reg;
    last_next    = last_reg;
    pop_vec      = '0;
    case (state_reg)
      IDLE: begin
        if (|(~empty_vec)) begin
          pop_vec[winner] = 1'b1;
          tx_data_next    = pop_data_arr[winner];
          tx_src_next     = winner;
          state_next      = START;
        end
      end
      START: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (tx_done_tick) begin
          last_next  = tx_src_reg;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sticky overflow: a clear and a same-cycle drop leave the bit set.
  always_comb begin
    ovf_next = ovf_clr ? 2'b00 : ovf_reg;
    ovf_next = ovf_next | (push_vec & full_vec);
  end

  // State, holding registers and round-robin memory; last starts at 1 so
  // requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      tx_data_reg <= '0;
      tx_src_reg  <= 1'b0;
      last_reg    <= 1'b1;
      ovf_reg     <= 2'b00;
    end else begin
      state_reg   <= state_next;
      tx_data_reg <= tx_data_next;
      tx_src_reg  <= tx_src_next;
      last_reg    <= last_next;
      ovf_reg     <= ovf_next;
    end
  end

  assign tx_start   = (state_reg == START);
  assign busy       = (state_reg == START) || (state_reg == WAIT);
  assign tx_data    = tx_data_reg;
  assign tx_src     = tx_src_reg;
  assign ovf        = ovf_reg;
  assign req0_ready = ~full_vec[REQ_KBD];
  assign req1_ready = ~full_vec[REQ_DBG];

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios followed by a
// randomized run, all checked every cycle against a queue-based model.
module tb_uart_tx_arb;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_done_tick;
  logic          tx_src;
  logic          busy;
  logic [1:0]    ovf;
  logic          ovf_clr;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .tx_src       (tx_src),
    .busy         (busy),
    .ovf          (ovf),
    .ovf_clr      (ovf_clr)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: per-requester byte queues, a transfer phase
  // (0 = nothing in flight, 1 = start pulse cycle, 2 = awaiting done),
  // the byte/source currently owned by the transmitter, and fairness memory.
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int         m_phase;
  logic       m_last;
  logic       m_src;
  logic [7:0] m_data;
  logic [1:0] m_ovf;

  logic [8:0] sent [$];   // {src, data} for each observed tx_start

  // Bench-side transmitter: answers tx_done_tick tx_delay cycles into WAIT.
  bit auto_en  = 1'b0;
  int tx_delay = 3;
  int wait_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic f0;
    logic f1;
    logic win;
    if (!reset) begin
      q0.delete();
      q1.delete();
      m_phase = 0;
      m_last  = 1'b1;
      m_src   = 1'b0;
      m_data  = 8'h00;
      m_ovf   = 2'b00;
      return;
    end
    f0 = (q0.size() == DEPTH);
    f1 = (q1.size() == DEPTH);
    case (m_phase)
      0: begin
        if (q0.size() != 0 || q1.size() != 0) begin
          if (q0.size() != 0 && q1.size() != 0) win = ~m_last;
          else win = (q0.size() == 0);
          if (win == 1'b0) m_data = q0.pop_front();
          else m_data = q1.pop_front();
          m_src   = win;
          m_phase = 1;
        end
      end
      1: m_phase = 2;
      default: begin
        if (tx_done_tick) begin
          m_phase = 0;
          m_last  = m_src;
        end
      end
    endcase
    if (ovf_clr) m_ovf = 2'b00;
    if (req0_valid) begin
      if (f0) m_ovf[0] = 1'b1;
      else q0.push_back(req0_data);
    end
    if (req1_valid) begin
      if (f1) m_ovf[1] = 1'b1;
      else q1.push_back(req1_data);
    end
  endtask

  // One clock cycle: apply current drive, update model at the edge, compare
  // shortly after, then drop single-cycle strobes.
  task automatic tick();
    if (auto_en && m_phase == 2) begin
      if (wait_cnt >= tx_delay) begin
        tx_done_tick = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    @(posedge clk);
    model_step();
    #1;
    check_eq("tx_start", tx_start, m_phase == 1);
    check_eq("busy", busy, m_phase != 0);
    check_eq("tx_data", tx_data, m_data);
    check_eq("tx_src", tx_src, m_src);
    check_eq("ovf", ovf, m_ovf);
    check_eq("req0_ready", req0_ready, q0.size() < DEPTH);
    check_eq("req1_ready", req1_ready, q1.size() < DEPTH);
    if (tx_start) begin
      sent.push_back({tx_src, tx_data});
      $display("tx byte=%02h src=%0d", tx_data, tx_src);
    end
    req0_valid   = 1'b0;
    req1_valid   = 1'b0;
    tx_done_tick = 1'b0;
    ovf_clr      = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    sent.delete();
  endtask

  task automatic push0(input logic [7:0] b);
    req0_valid = 1'b1;
    req0_data  = b;
    tick();
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget && !busy; i++) tick();
    check_eq("wait_busy", busy, 1'b1);
  endtask

  task automatic check_sent(input string tag, input logic [8:0] exp [$]);
    check_eq({tag, "_count"}, sent.size(), exp.size());
    for (int i = 0; i < exp.size() && i < sent.size(); i++) begin
      check_eq(tag, sent[i], exp[i]);
    end
  endtask

  initial begin
    logic [8:0] exp_q [$];
    reset        = 1'b0;
    req0_valid   = 1'b0;
    req0_data    = '0;
    req1_valid   = 1'b0;
    req1_data    = '0;
    tx_done_tick = 1'b0;
    ovf_clr      = 1'b0;
    m_phase = 0; m_last = 1'b1; m_src = 1'b0; m_data = 8'h00; m_ovf = 2'b00;

    // Reset state and single byte from requester 0.
    do_reset();
    check_eq("rst_ready0", req0_ready, 1'b1);
    check_eq("rst_ready1", req1_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    push0(8'h41);
    tick();
    check_eq("t1_start", tx_start, 1'b1);
    check_eq("t1_data", tx_data, 8'h41);
    check_eq("t1_src", tx_src, 1'b0);
    run(19);
    tx_done_tick = 1'b1;
    tick();
    check_eq("t1_busy_low", busy, 1'b0);
    exp_q = '{9'h041};
    check_sent("t1_sent", exp_q);

    // Simultaneous pushes from both requesters alternate, requester 0 first.
    do_reset();
    auto_en  = 1'b1;
    tx_delay = 5;
    req0_valid = 1'b1; req0_data = 8'h61; req1_valid = 1'b1; req1_data = 8'h31; tick();
    req0_valid = 1'b1; req0_data = 8'h62; req1_valid = 1'b1; req1_data = 8'h32; tick();
    run(60);
    exp_q = '{9'h061, 9'h131, 9'h062, 9'h132};
    check_sent("t2_order", exp_q);

    // Overflow while the transmitter is stalled.
    do_reset();
    auto_en = 1'b0;
    push0(8'h0F);
    wait_busy(5);
    for (int i = 0; i < 4; i++) push0(8'(8'h10 + i));
    check_eq("t3_ready0_full", req0_ready, 1'b0);
    push0(8'h14);
    check_eq("t3_ovf", ovf, 2'b01);
    ovf_clr = 1'b1;
    tick();
    check_eq("t3_ovf_clr", ovf, 2'b00);
    auto_en = 1'b1;
    run(80);
    exp_q = '{9'h00F, 9'h010, 9'h011, 9'h012, 9'h013};
    check_sent("t3_sent", exp_q);

    // Push to a full FIFO in the same cycle it pops.
    do_reset();
    auto_en = 1'b0;
    push0(8'hA0);
    wait_busy(5);
    for (int i = 1; i <= 4; i++) push0(8'(8'hA0 + i));
    tx_done_tick = 1'b1;
    tick();
    push0(8'hA5);
    check_eq("t4_ovf_pop_push", ovf, 2'b01);
    check_eq("t4_ready0", req0_ready, 1'b1);
    auto_en = 1'b1;
    run(80);
    exp_q = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4};
    check_sent("t4_sent", exp_q);

    // Pointer wrap: eight bytes spread over time.
    do_reset();
    tx_delay = 2;
    for (int i = 0; i < 8; i++) begin
      push0(8'(i));
      run($urandom_range(0, 6));
    end
    run(80);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(9'(i));
    check_sent("t5_wrap", exp_q);

    // Reset in WAIT with bytes queued flushes everything.
    do_reset();
    auto_en = 1'b0;
    push0(8'hB0);
    wait_busy(5);
    push0(8'hB1);
    push0(8'hB2);
    req1_valid = 1'b1; req1_data = 8'hC0; tick();
    check_eq("t6_busy_before", busy, 1'b1);
    reset = 1'b0;
    tick();
    check_eq("t6_start_after_rst", tx_start, 1'b0);
    check_eq("t6_busy_after_rst", busy, 1'b0);
    reset = 1'b1;
    sent.delete();
    auto_en = 1'b1;
    run(10);
    check_eq("t6_no_start", sent.size(), 0);
    check_eq("t6_ready0", req0_ready, 1'b1);
    check_eq("t6_ready1", req1_ready, 1'b1);

    // Stray done ticks in IDLE and START are ignored.
    do_reset();
    auto_en = 1'b0;
    tx_done_tick = 1'b1;
    tick();
    check_eq("t7_idle_done", busy, 1'b0);
    push0(8'hD0);
    tick();
    check_eq("t7_start", tx_start, 1'b1);
    tx_done_tick = 1'b1;
    tick();
    check_eq("t7_start_done_busy", busy, 1'b1);
    check_eq("t7_start_done_nostart", tx_start, 1'b0);
    run(5);
    check_eq("t7_one_start", sent.size(), 1);
    tx_done_tick = 1'b1;
    tick();

    // Randomized traffic against the model.
    do_reset();
    auto_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      req0_valid = ($urandom_range(0, 2) == 0);
      req0_data  = 8'($urandom);
      req1_valid = ($urandom_range(0, 3) == 0);
      req1_data  = 8'($urandom);
      ovf_clr    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) tx_done_tick = 1'b1;
      if ($urandom_range(0, 99) == 0) tx_delay = $urandom_range(0, 8);
      reset = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
